// File: rtl/sw_debouncer.sv
// Multi-bit slide-switch debouncer: each raw line is synchronized, then accepted
// only after it holds a new level for STABLE_CYCLES consecutive clocks.
module sw_debouncer #(
  parameter int WIDTH         = 6,
  parameter int STABLE_CYCLES = 100000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] SW,
  output logic             sw_changed
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0]         sync1_reg;
  logic [WIDTH-1:0]         sync2_reg;
  logic [WIDTH-1:0]         sw_reg;
  logic [WIDTH-1:0]         sw_next;
  logic [WIDTH-1:0]         load;
  logic                     sw_changed_reg;
  logic [WIDTH-1:0][CW-1:0] cnt_reg;
  logic [WIDTH-1:0][CW-1:0] cnt_next;

  // Per-bit qualification; a bounce back to the accepted level clears the count.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic differs;
      logic at_max;

      assign differs       = sync2_reg[gi] ^ sw_reg[gi];
      assign at_max        = (cnt_reg[gi] == CNT_MAX);
      assign load[gi]      = differs & at_max;
      assign cnt_next[gi]  = (differs && !at_max) ? cnt_reg[gi] + CW'(1) : '0;
      assign sw_next[gi]   = load[gi] ? sync2_reg[gi] : sw_reg[gi];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_reg      <= '0;
      sync2_reg      <= '0;
      sw_reg         <= '0;
      cnt_reg        <= '0;
      sw_changed_reg <= 1'b0;
    end else begin
      sync1_reg      <= sw_raw;
      sync2_reg      <= sync1_reg;
      sw_reg         <= sw_next;
      cnt_reg        <= cnt_next;
      sw_changed_reg <= |load;
    end
  end

  assign SW         = sw_reg;
  assign sw_changed = sw_changed_reg;

endmodule

// File: tb/tb_sw_debouncer.sv
// Directed bench for sw_debouncer with WIDTH=6, STABLE_CYCLES=4: a vector table
// for reset/latency/glitch cases plus hand-written multi-cycle sequences.
module tb_sw_debouncer;

  typedef struct {
    logic       rst_n;
    logic [5:0] raw;
    logic [5:0] exp_sw;
    logic       exp_chg;
  } vec_t;

  logic       clock;
  logic       reset;
  logic [5:0] sw_raw;
  logic [5:0] SW;
  logic       sw_changed;

  int checks   = 0;
  int failures = 0;
  int step_no  = 0;

  vec_t vecs[$];

  sw_debouncer #(
    .WIDTH        (6),
    .STABLE_CYCLES(4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .sw_raw    (sw_raw),
    .SW        (SW),
    .sw_changed(sw_changed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void add(input int n, input logic r, input logic [5:0] raw,
                              input logic [5:0] esw, input logic echg);
    vec_t v;
    v.rst_n   = r;
    v.raw     = raw;
    v.exp_sw  = esw;
    v.exp_chg = echg;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  // Drive inputs for one edge, then check outputs 1 ns after that edge.
  task automatic step(input logic r, input logic [5:0] raw, input logic [5:0] esw,
                      input logic echg, input string name);
    reset  = r;
    sw_raw = raw;
    @(posedge clock);
    #1;
    step_no++;
    checks++;
    if (SW !== esw) begin
      failures++;
      $display("FAIL %s step %0d: SW=%b expected %b", name, step_no, SW, esw);
    end
    checks++;
    if (sw_changed !== echg) begin
      failures++;
      $display("FAIL %s step %0d: sw_changed=%b expected %b", name, step_no, sw_changed, echg);
    end
    $display("step %0d %s: rst_n=%b raw=%b SW=%b chg=%b", step_no, name, r, raw, SW, sw_changed);
  endtask

  initial begin
    reset  = 1'b0;
    sw_raw = 6'b000000;

    // Reset, release with all bits high, then fall back to 0.
    add(2,  1'b0, 6'h3F, 6'h00, 1'b0);
    add(5,  1'b1, 6'h3F, 6'h00, 1'b0);
    add(1,  1'b1, 6'h3F, 6'h3F, 1'b1);
    add(1,  1'b1, 6'h3F, 6'h3F, 1'b0);
    add(5,  1'b1, 6'h00, 6'h3F, 1'b0);
    add(1,  1'b1, 6'h00, 6'h00, 1'b1);
    add(1,  1'b1, 6'h00, 6'h00, 1'b0);
    // Single bit 0 rise and fall.
    add(5,  1'b1, 6'h01, 6'h00, 1'b0);
    add(1,  1'b1, 6'h01, 6'h01, 1'b1);
    add(1,  1'b1, 6'h01, 6'h01, 1'b0);
    add(5,  1'b1, 6'h00, 6'h01, 1'b0);
    add(1,  1'b1, 6'h00, 6'h00, 1'b1);
    add(1,  1'b1, 6'h00, 6'h00, 1'b0);
    // Three-cycle glitch on bit 0 must be rejected.
    add(3,  1'b1, 6'h01, 6'h00, 1'b0);
    add(20, 1'b1, 6'h00, 6'h00, 1'b0);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].rst_n, vecs[i].raw, vecs[i].exp_sw, vecs[i].exp_chg, "table");

    // Bit 5 bounces 1,0,1 then holds; accepted 6 edges after the last transition.
    for (int i = 0; i < 2; i++) step(1'b1, 6'h20, 6'h00, 1'b0, "bounce5");
    for (int i = 0; i < 2; i++) step(1'b1, 6'h00, 6'h00, 1'b0, "bounce5");
    for (int i = 0; i < 5; i++) step(1'b1, 6'h20, 6'h00, 1'b0, "bounce5");
    step(1'b1, 6'h20, 6'h20, 1'b1, "bounce5_rise");
    for (int i = 0; i < 3; i++) step(1'b1, 6'h20, 6'h20, 1'b0, "bounce5_hold");

    // Bits 0 and 1 together: one pulse.
    for (int i = 0; i < 5; i++) step(1'b1, 6'h23, 6'h20, 1'b0, "same_edge");
    step(1'b1, 6'h23, 6'h23, 1'b1, "same_edge_rise");
    step(1'b1, 6'h23, 6'h23, 1'b0, "same_edge_hold");

    // Bits 2 and 3 two cycles apart: two pulses two cycles apart.
    for (int i = 0; i < 2; i++) step(1'b1, 6'h27, 6'h23, 1'b0, "split");
    for (int i = 0; i < 3; i++) step(1'b1, 6'h2F, 6'h23, 1'b0, "split");
    step(1'b1, 6'h2F, 6'h27, 1'b1, "split_bit2");
    step(1'b1, 6'h2F, 6'h27, 1'b0, "split_gap");
    step(1'b1, 6'h2F, 6'h2F, 1'b1, "split_bit3");
    for (int i = 0; i < 2; i++) step(1'b1, 6'h2F, 6'h2F, 1'b0, "split_hold");

    // Reset mid-qualification on the edge that would otherwise load.
    for (int i = 0; i < 2; i++) step(1'b0, 6'h10, 6'h00, 1'b0, "midrst_reset");
    for (int i = 0; i < 5; i++) step(1'b1, 6'h10, 6'h00, 1'b0, "midrst_count");
    step(1'b0, 6'h10, 6'h00, 1'b0, "midrst_abort");
    for (int i = 0; i < 5; i++) step(1'b1, 6'h10, 6'h00, 1'b0, "midrst_requal");
    step(1'b1, 6'h10, 6'h10, 1'b1, "midrst_rise");
    step(1'b1, 6'h10, 6'h10, 1'b0, "midrst_hold");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
